// File: rtl/register_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : register_write_arbiter                                    |
// | Purpose  : Shares the register file write port between a primary    |
// |            (A) and secondary (B) writeback requester, zero-fills    |
// |            x1..x31 after reset or flush, and bounds B starvation.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module register_write_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             Req_A,
  input  logic [4:0]       Rd_A,
  input  logic [WIDTH-1:0] WD_A,
  input  logic             Req_B,
  input  logic [4:0]       Rd_B,
  input  logic [WIDTH-1:0] WD_B,
  output logic             Gnt_A,
  output logic             Gnt_B,
  output logic             Busy,
  output logic             WE,
  output logic [4:0]       Rd,
  output logic [WIDTH-1:0] WD
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
  localparam logic [4:0] LAST_IDX_C     = 5'd31;

  state_t           state_q, state_d;
  logic [4:0]       clr_idx_q, clr_idx_d;
  logic [3:0]       starve_q, starve_d;
  logic             we_q, we_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] wd_q, wd_d;

  // State, clear index, starvation counter and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= 5'd1;
      starve_q  <= 4'd0;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      starve_q  <= starve_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wd_q      <= wd_d;
    end
  end

  // Next-state logic: clear sequencing, arbitration, grants and starvation.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    starve_d  = starve_q;
    we_d      = 1'b0;
    rd_d      = rd_q;
    wd_d      = wd_q;
    Gnt_A     = 1'b0;
    Gnt_B     = 1'b0;
    Busy      = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        // B cannot lose arbitration while clearing, so its counter stays 0.
        Busy     = 1'b1;
        we_d     = 1'b1;
        rd_d     = clr_idx_q;
        wd_d     = '0;
        starve_d = 4'd0;
        if (Flush) begin
          clr_idx_d = 5'd1;
        end else begin
          clr_idx_d = clr_idx_q + 5'd1;
          if (clr_idx_q == LAST_IDX_C) begin
            state_d = ST_ARB;
          end
        end
      end

      default: begin
        if (Flush) begin
          state_d   = ST_CLEAR;
          clr_idx_d = 5'd1;
          starve_d  = 4'd0;
        end else begin
          // B wins only when it has been starved up to the limit.
          if ((starve_q == STARVE_LIMIT_C) && Req_B) begin
            Gnt_B = 1'b1;
          end else if (Req_A) begin
            Gnt_A = 1'b1;
          end else if (Req_B) begin
            Gnt_B = 1'b1;
          end

          // A write to x0 is consumed but never issued.
          if (Gnt_A) begin
            we_d = (Rd_A != 5'd0);
            rd_d = Rd_A;
            wd_d = WD_A;
          end else if (Gnt_B) begin
            we_d = (Rd_B != 5'd0);
            rd_d = Rd_B;
            wd_d = WD_B;
          end

          if (Gnt_B || !Req_B) begin
            starve_d = 4'd0;
          end else if (starve_q < STARVE_LIMIT_C) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
    endcase
  end

  assign WE = we_q;
  assign Rd = rd_q;
  assign WD = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_register_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_register_write_arbiter                                 |
// | Purpose  : Directed self-checking bench for register_write_arbiter,  |
// |            with a small register file model on the write port.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_register_write_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             Flush;
  logic             Req_A;
  logic [4:0]       Rd_A;
  logic [WIDTH-1:0] WD_A;
  logic             Req_B;
  logic [4:0]       Rd_B;
  logic [WIDTH-1:0] WD_B;
  logic             Gnt_A;
  logic             Gnt_B;
  logic             Busy;
  logic             WE;
  logic [4:0]       Rd;
  logic [WIDTH-1:0] WD;

  int errors = 0;
  int checks = 0;

  register_write_arbiter #(.WIDTH(WIDTH), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .Flush (Flush),
    .Req_A (Req_A),
    .Rd_A  (Rd_A),
    .WD_A  (WD_A),
    .Req_B (Req_B),
    .Rd_B  (Rd_B),
    .WD_B  (WD_B),
    .Gnt_A (Gnt_A),
    .Gnt_B (Gnt_B),
    .Busy  (Busy),
    .WE    (WE),
    .Rd    (Rd),
    .WD    (WD)
  );

  always #5 clk = ~clk;

  // Register file model: x0 starts at 0, others start non-zero so the clear is visible.
  logic [WIDTH-1:0] rf [32];
  logic             rf_init;
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? '0 : 32'hFFFF_FFFF;
    end else if (WE) begin
      rf[Rd] <= WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; Flush = 1'b0;
    Req_A = 1'b0; Rd_A = '0; WD_A = '0;
    Req_B = 1'b0; Rd_B = '0; WD_B = '0;
    rf_init = 1'b1;
    tick();
    rf_init = 1'b0;
    tick();

    // Reset values
    chk("rst_we",   32'(WE),    32'd0);
    chk("rst_rd",   32'(Rd),    32'd0);
    chk("rst_wd",   WD,         32'd0);
    chk("rst_busy", 32'(Busy),  32'd1);
    chk("rst_gnta", 32'(Gnt_A), 32'd0);
    chk("rst_gntb", 32'(Gnt_B), 32'd0);

    // Clear sequence after reset release
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      chk("clr_busy", 32'(Busy), 32'd1);
      tick();
      chk("clr_we", 32'(WE), 32'd1);
      chk("clr_rd", 32'(Rd), 32'(k));
      chk("clr_wd", WD, 32'd0);
    end
    chk("clr_busy_fall", 32'(Busy), 32'd0);

    // A only
    Req_A = 1'b1; Rd_A = 5'd5; WD_A = 32'hDEAD_BEEF;
    #1;
    chk("aonly_gnta", 32'(Gnt_A), 32'd1);
    chk("aonly_gntb", 32'(Gnt_B), 32'd0);
    tick();
    Req_A = 1'b0;
    chk("aonly_we", 32'(WE), 32'd1);
    chk("aonly_rd", 32'(Rd), 32'd5);
    chk("aonly_wd", WD, 32'hDEAD_BEEF);
    for (int r = 1; r <= 31; r++) chk("rf_cleared", rf[r], 32'd0);
    tick();
    chk("aonly_idle_we", 32'(WE), 32'd0);
    chk("aonly_hold_rd", 32'(Rd), 32'd5);
    chk("aonly_rf5", rf[5], 32'hDEAD_BEEF);

    // Contention on the same Rd: A wins 4 times, then B once, then A again
    Req_A = 1'b1; Rd_A = 5'd3; WD_A = 32'hAAAA_0003;
    Req_B = 1'b1; Rd_B = 5'd3; WD_B = 32'hBBBB_0003;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c == 5) chk("cont_starve_before", 32'(dut.starve_q), 32'd4);
      chk("cont_gnta", 32'(Gnt_A), (c == 5) ? 32'd0 : 32'd1);
      chk("cont_gntb", 32'(Gnt_B), (c == 5) ? 32'd1 : 32'd0);
      tick();
      chk("cont_rd", 32'(Rd), 32'd3);
      chk("cont_wd", WD, (c == 5) ? 32'hBBBB_0003 : 32'hAAAA_0003);
      if (c == 5) chk("cont_starve_after", 32'(dut.starve_q), 32'd0);
    end
    Req_A = 1'b0; Req_B = 1'b0;
    tick();

    // x0 write is consumed but not issued
    Req_B = 1'b1; Rd_B = 5'd0; WD_B = 32'h0000_1234;
    #1;
    chk("x0_gntb", 32'(Gnt_B), 32'd1);
    chk("x0_gnta", 32'(Gnt_A), 32'd0);
    tick();
    Req_B = 1'b0;
    chk("x0_we", 32'(WE), 32'd0);
    chk("x0_rd", 32'(Rd), 32'd0);
    tick();
    chk("x0_rf0", rf[0], 32'd0);
    chk("x0_rf3", rf[3], 32'hAAAA_0003);

    // Flush during ARB with a pending A request
    Req_A = 1'b1; Rd_A = 5'd7; WD_A = 32'h0000_0077; Flush = 1'b1;
    #1;
    chk("flush_gnta", 32'(Gnt_A), 32'd0);
    tick();
    Flush = 1'b0;
    chk("flush_we", 32'(WE), 32'd0);
    for (int k = 1; k <= 31; k++) begin
      chk("fclr_busy", 32'(Busy), 32'd1);
      chk("fclr_gnta", 32'(Gnt_A), 32'd0);
      tick();
      chk("fclr_we", 32'(WE), 32'd1);
      chk("fclr_rd", 32'(Rd), 32'(k));
    end
    chk("fclr_busy_fall", 32'(Busy), 32'd0);
    chk("fclr_gnta_after", 32'(Gnt_A), 32'd1);
    tick();
    Req_A = 1'b0;
    chk("fclr_a_we", 32'(WE), 32'd1);
    chk("fclr_a_rd", 32'(Rd), 32'd7);
    chk("fclr_a_wd", WD, 32'h0000_0077);

    // Async reset mid-clear at Clr_Idx=12
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    chk("ar_rd11", 32'(Rd), 32'd11);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_we_async", 32'(WE), 32'd0);
    chk("ar_rd_async", 32'(Rd), 32'd0);
    chk("ar_busy", 32'(Busy), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_restart_rd", 32'(Rd), 32'd1);
    chk("ar_restart_we", 32'(WE), 32'd1);
    tick();
    chk("ar_rd2", 32'(Rd), 32'd2);

    // Flush in CLEAR: current index still written, then restart at 1
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("fic_rd3", 32'(Rd), 32'd3);
    chk("fic_we", 32'(WE), 32'd1);
    tick();
    chk("fic_restart_rd", 32'(Rd), 32'd1);
    tick();
    chk("fic_rd2", 32'(Rd), 32'd2);
    chk("fic_busy", 32'(Busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_write_arbiter.md
# register_write_arbiter

Shares the single write port of the processor register file between two writeback requesters and sequences a zero-fill of x1..x31 after reset or on flush. Requester A is the primary writeback (ALU/pipeline) and requester B is the secondary writeback (load/multi-cycle unit). A starvation counter guarantees B forward progress. The block's registered WE/Rd/WD outputs drive the register file write port directly.

## Interface

- WIDTH, 32, data width; matches the register file WIDTH.
- STARVE_LIMIT, 4, consecutive lost cycles after which B gets priority (range 1..15).

- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  asynchronous, active-high reset.
- Flush  input  1  synchronous request to restart the clear sequence.
- Req_A  input  1  requester A write request.
- Rd_A  input  5  requester A destination register.
- WD_A  input  WIDTH  requester A write data.
- Req_B  input  1  requester B write request.
- Rd_B  input  5  requester B destination register.
- WD_B  input  WIDTH  requester B write data.
- Gnt_A  output  1  combinational grant to A, same cycle as the request.
- Gnt_B  output  1  combinational grant to B, same cycle as the request.
- Busy  output  1  high while in the CLEAR state.
- WE  output  1  registered register file write enable.
- Rd  output  5  registered register file destination.
- WD  output  WIDTH  registered register file write data.

## Operation

- There are two states: CLEAR and ARB. reset forces CLEAR, sets Clr_Idx=1 and sets Starve_Cnt=0.
- **CLEAR**
  - Each edge loads WE=1, Rd=Clr_Idx, WD=0, then increments Clr_Idx.
  - The edge that issues Clr_Idx=31 also moves the state to ARB.
  - Gnt_A=Gnt_B=0 and Busy=1 throughout.
- **ARB, no Flush**
  - B has priority when Starve_Cnt==STARVE_LIMIT. Otherwise A has priority.
  - Only one grant is asserted in a cycle; the other is 0.
  - A grant is asserted only when the matching Req is high.
  - Next-edge outputs:
    - Winner present: WE = (winner Rd != 0), Rd and WD = winner's values.
    - No request: WE=0, and Rd/WD hold their previous values.
  - A request with Rd==0 is still granted (it is consumed), but no write is issued. This keeps x0 hard-wired to zero.
  - Requests with the same Rd from A and B are never merged. The loser retries in a later cycle.
- **Starve_Cnt** (saturating, 4 bits)
  - Cleared when Gnt_B=1 or Req_B=0.
  - Otherwise incremented when Req_B=1 and Gnt_B=0.
  - Saturates at STARVE_LIMIT.
- **Flush in ARB**
  - Grants are 0 in the Flush cycle.
  - The next edge enters CLEAR with Clr_Idx=1, loads WE=0, and sets Starve_Cnt=0.
- **Flush in CLEAR**
  - Clr_Idx restarts at 1 on the next edge.
  - That edge still issues a zero write at the current index.
- **Requester protocol**
  - A requester holds Req, Rd and WD stable until granted.
  - It may drop Req at any time without penalty.

## Timing

- Reset values: WE=0, Rd=0, WD=0, Busy=1, Gnt_A=0, Gnt_B=0. State=CLEAR, Clr_Idx=1, Starve_Cnt=0.
- The clear sequence takes 31 edges after reset release.
  - Edge k (k=1..31) loads Rd=k.
  - Busy falls after edge 31, so the first grant is possible in the cycle after edge 31.
- Write latency:
  - Grant in cycle N; WE/Rd/WD are registered at the end of cycle N.
  - The register file captures the write at the end of cycle N+1.
  - A read of that Rd during N+1 returns the old value.
  - Hazard logic uses WE and Rd as the pending-write indication.
- Starvation bound: once Req_B is held, B is granted no later than STARVE_LIMIT+1 cycles after it first loses.
- Reset mid-operation: asynchronous return to the reset values. A grant in the same cycle is discarded, and the requester must re-request.

## Test plan

- **Reset clear sequence.** Release reset with no requests.
  - WE=1 and WD=0 on edges 1..31, with Rd=1,2,…,31.
  - Busy=1 until edge 31, then 0.
  - Register file reads return 0 for all x1..x31.
- **A only.** Req_A with Rd_A=5, WD_A=0xDEADBEEF for one cycle.
  - Gnt_A=1 in the same cycle.
  - Next cycle: WE=1, Rd=5, WD=0xDEADBEEF.
  - RD1 for Rs1=5 reads 0xDEADBEEF one cycle later.
- **Contention.** Req_A (Rd 3) and Req_B (Rd 3) held together, STARVE_LIMIT=4.
  - Gnt_A in cycles 1–4.
  - Gnt_B in cycle 5, with Starve_Cnt=4 before it.
  - Starve_Cnt=0 after cycle 5, and A wins again in cycle 6.
- **x0 drop.** Req_B with Rd_B=0, WD_B=0x1234.
  - Gnt_B=1, next-cycle WE=0, and x0 still reads 0.
- **Flush during ARB with pending Req_A.**
  - Gnt_A=0 in the Flush cycle.
  - Next edges rerun the 31-write clear, with Busy=1 for 31 cycles.
  - Gnt_A is asserted after Busy falls.
- **Async reset mid-clear.** Assert reset at Clr_Idx=12.
  - WE drops to 0 immediately, without waiting for a clock edge.
  - After release, the sequence restarts at Rd=1.
